// File: rtl/cc_pkg.sv
// Shared cache-controller types: hit-line geometry and the hit-data FIFO entry layout.
package cc_pkg;

  localparam int CC_BEAT_WIDTH      = 64;
  localparam int CC_LINE_BEATS      = 8;
  localparam int CC_OFFSET_WIDTH    = 6;
  localparam int CC_HIT_ENTRY_WIDTH = CC_LINE_BEATS * CC_BEAT_WIDTH + CC_OFFSET_WIDTH;

  typedef logic [CC_LINE_BEATS*CC_BEAT_WIDTH-1:0] cc_line_t;
  typedef logic [CC_OFFSET_WIDTH-1:0]             cc_offset_t;
  typedef logic [$clog2(CC_LINE_BEATS)-1:0]       cc_beat_idx_t;

  typedef struct packed {
    cc_offset_t offset;
    cc_line_t   line;
  } cc_hit_entry_t;

endpackage

// File: rtl/cc_hit_line_serializer.sv
// Serializes one popped hit-line entry into a critical-word-first, wrapping burst of
// LINE_BEATS beats, back-to-back across lines when the FIFO has more data.
module cc_hit_line_serializer
  import cc_pkg::*;
#(
  parameter  int BEAT_WIDTH   = CC_BEAT_WIDTH,
  parameter  int LINE_BEATS   = CC_LINE_BEATS,
  parameter  int OFFSET_WIDTH = CC_OFFSET_WIDTH,
  localparam int ENTRY_WIDTH  = LINE_BEATS * BEAT_WIDTH + OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty_i,
  input  logic [ENTRY_WIDTH-1:0] fifo_rdata_i,
  output logic                   fifo_rden_o,
  output logic [BEAT_WIDTH-1:0]  rdata_o,
  output logic                   rlast_o,
  output logic                   rvalid_o,
  input  logic                   rready_i
);

  localparam int LINE_W = LINE_BEATS * BEAT_WIDTH;
  localparam int PTR_W  = $clog2(LINE_BEATS);
  localparam int BYTE_W = $clog2(BEAT_WIDTH / 8);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                 state;
  logic [LINE_BEATS-1:0][BEAT_WIDTH-1:0]  line_q;
  logic [PTR_W-1:0]                       ptr;
  logic [PTR_W-1:0]                       cnt;

  logic [OFFSET_WIDTH-1:0] in_off;
  logic [PTR_W-1:0]        in_ptr;
  logic                    last, hs, pop;
  logic                    unused_byte_off;

  // Byte-within-beat offset bits are dropped: bursts always start beat-aligned.
  assign in_off          = fifo_rdata_i[ENTRY_WIDTH-1 -: OFFSET_WIDTH];
  assign in_ptr          = in_off[BYTE_W +: PTR_W];
  assign unused_byte_off = ^in_off[BYTE_W-1:0];

  assign last = (cnt == PTR_W'(LINE_BEATS - 1));
  assign hs   = (state == SEND) && rready_i;
  // A pop either starts a burst from IDLE or chains the next line onto the last beat.
  assign pop  = !rst && !fifo_empty_i && ((state == IDLE) || (hs && last));

  assign fifo_rden_o = pop;
  assign rvalid_o    = (state == SEND);
  assign rlast_o     = rvalid_o && last;
  assign rdata_o     = rvalid_o ? line_q[ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      line_q <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            line_q <= fifo_rdata_i[LINE_W-1:0];
            ptr    <= in_ptr;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (!last) begin
              ptr <= ptr + 1'b1;
              cnt <= cnt + 1'b1;
            end else if (pop) begin
              line_q <= fifo_rdata_i[LINE_W-1:0];
              ptr    <= in_ptr;
              cnt    <= '0;
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_hit_line_serializer.sv
// Directed bench: FIFO model feeds entries, scoreboard holds expected beats per pushed entry.
module tb_cc_hit_line_serializer;
  import cc_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          fifo_empty = 1'b1;
  logic [CC_HIT_ENTRY_WIDTH-1:0] fifo_rdata = '0;
  logic                          fifo_rden;
  logic [63:0]                   rdata;
  logic                          rlast, rvalid;
  logic                          rready = 1'b1;

  cc_hit_line_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rden_o  (fifo_rden),
    .rdata_o      (rdata),
    .rlast_o      (rlast),
    .rvalid_o     (rvalid),
    .rready_i     (rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  cc_hit_entry_t fifo_q[$];
  beat_t         exp_q[$];
  int            rden_log[$];

  int total = 0, bad = 0;
  int cyc = 0, last_rden = -10, hs_cnt = 0, run = 0, max_run = 0;
  logic pop_pend = 1'b0, prev_valid = 1'b0, stalled = 1'b0, held_last = 1'b0;
  logic [63:0] held_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
  endtask

  function automatic logic [63:0] word(input logic [15:0] tag, input logic [3:0] i);
    return {tag, 44'h0, i};
  endfunction

  task automatic push_entry(input logic [15:0] tag, input logic [5:0] off);
    cc_hit_entry_t e;
    logic [2:0]    w;
    beat_t         b;
    e.offset = off;
    for (int i = 0; i < 8; i++) e.line[64*i +: 64] = word(tag, 4'(i));
    fifo_q.push_back(e);
    refresh();
    for (int k = 0; k < 8; k++) begin
      w      = off[5:3] + 3'(k);
      b.last = (k == 7);
      b.data = word(tag, {1'b0, w});
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rvalid || fifo_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
  endtask

  // FIFO model: a pop seen at the negedge takes effect just after the next rising edge.
  always @(posedge clk) begin
    if (pop_pend) begin
      pop_pend = 1'b0;
      #1;
      void'(fifo_q.pop_front());
      refresh();
    end
  end

  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
      stalled    = 1'b0;
      run        = 0;
      pop_pend   = 1'b0;
    end else begin
      pop_pend = fifo_rden;
      if (fifo_rden) begin
        rden_log.push_back(cyc);
        last_rden = cyc;
      end
      if (rvalid && fifo_rden) check("rden_only_on_last_hs", {62'h0, rready, rlast}, 64'd3);
      if (rvalid && !prev_valid) check("first_beat_latency", 64'(cyc), 64'(last_rden + 1));
      if (stalled) begin
        check("stall_valid", 64'(rvalid), 64'd1);
        check("stall_data", rdata, held_data);
        check("stall_last", 64'(rlast), 64'(held_last));
      end
      run = rvalid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (rvalid && rready) begin
        hs_cnt++;
        check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("beat_data", rdata, b.data);
          check("beat_last", 64'(rlast), 64'(b.last));
        end
      end
      stalled    = rvalid && !rready;
      held_data  = rdata;
      held_last  = rlast;
      prev_valid = rvalid;
    end
  end

  initial begin
    int n, base, k;
    // Reset with an entry already waiting: nothing may pop or be presented.
    push_entry(16'h1111, 6'h00);
    #1;
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rden", 64'(fifo_rden), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // T1: offset 0, straight order
    wait_done("t1_timeout", 40);

    // Idle with empty FIFO
    repeat (2) @(posedge clk);
    #1;
    check("idle_rden", 64'(fifo_rden), 64'd0);
    check("idle_rvalid", 64'(rvalid), 64'd0);
    check("idle_rdata", rdata, 64'd0);

    // T2: start at w5 with wrap
    push_entry(16'h2222, 6'h2C);
    wait_done("t2_timeout", 40);

    // T3: byte bits ignored, start w0
    push_entry(16'h3333, 6'h07);
    wait_done("t3_timeout", 40);

    // T4: backpressure 1,0,0 pattern, start w2
    push_entry(16'h4444, 6'h10);
    base = hs_cnt;
    n = 0;
    k = 0;
    while (hs_cnt < base + 8 && n < 100) begin
      rready = (k % 3 == 0);
      @(posedge clk); #1;
      k++;
      n++;
    end
    rready = 1'b1;
    check("t4_handshakes", 64'(hs_cnt - base), 64'd8);
    wait_done("t4_timeout", 40);

    // T5: two queued lines stream without a bubble
    rden_log.delete();
    max_run = 0;
    push_entry(16'h5555, 6'h08);
    push_entry(16'h5A5A, 6'h38);
    wait_done("t5_timeout", 60);
    check("t5_rden_count", 64'(rden_log.size()), 64'd2);
    if (rden_log.size() == 2) check("t5_rden_spacing", 64'(rden_log[1] - rden_log[0]), 64'd8);
    check("t5_contig_valid", 64'(max_run), 64'd16);

    // T6: reset during beat 3 aborts the burst
    push_entry(16'h6666, 6'h18);
    base = hs_cnt;
    n = 0;
    while (hs_cnt < base + 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reach_beat3", 64'(hs_cnt - base), 64'd3);
    rst = 1'b1;
    #1;
    check("t6_rst_rvalid", 64'(rvalid), 64'd0);
    check("t6_rst_rlast", 64'(rlast), 64'd0);
    check("t6_rst_rdata", rdata, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_entry(16'h7777, 6'h30);
    wait_done("t6_timeout", 40);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
